alu_operand_fetch: RTL
======================

// Module: alu_operand_fetch
// PURPOSE
//   Operand-fetch stage directly upstream of the ALU. Holds the architectural register file
//   (regCount x dataWidth, x0 hard-wired zero), reads two source registers or an immediate,
//   and presents registered inputA/inputB/ALUSelect/outRd to the ALU via a valid/ready handshake.
//   Write-back port bypasses into same-cycle reads and refreshes operands held during a stall.
// PARAMETERS
//   dataWidth   32  operand/register width
//   selectWidth 4   ALU op-select width (0=ADD,1=SUB,2=MUL,3=AND,4=OR,5=XOR,6=NOT,7=SLL,8=SRL)
//   regCount    32  number of architectural registers
//   addrWidth   5   register address width, $clog2(regCount)
// PORTS
//   clk          in   1            single clock, rising edge
//   reset        in   1            asynchronous, active-high
//   inValid      in   1            upstream request valid
//   inReady      out  1            stage can accept request this cycle
//   inRs1        in   addrWidth    source register A
//   inRs2        in   addrWidth    source register B
//   inRd         in   addrWidth    destination register, passed through
//   inALUSelect  in   selectWidth  ALU operation, passed through
//   inUseImm     in   1            1: inputB takes inImm instead of reg[inRs2]
//   inImm        in   dataWidth    immediate operand
//   wbEnable     in   1            write-back strobe
//   wbAddr       in   addrWidth    write-back register
//   wbData       in   dataWidth    write-back data (ALU dataOut)
//   outValid     out  1            operands valid to ALU
//   outReady     in   1            ALU/downstream consumes operands
//   inputA       out  dataWidth    ALU operand A (registered)
//   inputB       out  dataWidth    ALU operand B (registered)
//   ALUSelect    out  selectWidth  ALU op (registered)
//   outRd        out  addrWidth    destination register (registered)
// BEHAVIOUR
//   - Reset (async, any time incl. mid-transfer): all registers 0, outValid 0, inputA/inputB 0,
//     ALUSelect 0 (ADD), outRd 0, held rs1/rs2/useImm 0. inReady = 1 after reset.
//   - inReady = !outValid || outReady (combinational). Accept = inValid && inReady.
//   - Accept: on next edge outValid<=1, capture operands, ALUSelect, outRd, rs1/rs2/useImm. Latency 1.
//   - No accept and outReady: outValid<=0; outputs keep last values. inValid w/ inReady=0: ignored,
//     upstream must hold request stable.
//   - Register write: edge with wbEnable && wbAddr!=0 -> reg[wbAddr]<=wbData. wbAddr==0 ignored.
//   - Read value: addr==0 -> 0; else wbEnable && wbAddr==addr -> wbData (bypass); else reg[addr].
//   - inputB on accept = inUseImm ? inImm : read(inRs2). inImm used full width, no extension.
//   - Stall refresh: outValid && !outReady && wbEnable && wbAddr!=0: if wbAddr==heldRs1 then
//     inputA<=wbData; if !heldUseImm && wbAddr==heldRs2 then inputB<=wbData. Both may update.
//   - Simultaneous accept + write-back to a source: bypassed wbData captured; reg also updated.
//   - Simultaneous accept + drain (outValid && outReady && inValid): new request captured,
//     outValid stays 1, no bubble.
//   - No internal FSM beyond outValid (EMPTY/FULL); throughput 1 request/cycle when outReady=1.
// TESTING
//   1. wb x5=0x8, x6=0x7; issue rs1=5 rs2=6 op=ADD rd=7 -> next cycle outValid=1, inputA=0x8,
//      inputB=0x7, ALUSelect=0, outRd=7.
//   2. Same cycle wbEnable x3=0x12345678 and issue rs1=3 rs2=0 -> inputA=0x12345678, inputB=0.
//   3. wb x0=0xFFFFFFFF then issue rs1=0 rs2=0 -> inputA=0, inputB=0.
//   4. Hold outReady=0 with held rs1=5; wb x5=0xAAAAAAAA -> inputA=0xAAAAAAAA next cycle,
//      outValid stays 1, inReady=0, second inValid not accepted until outReady=1.
//   5. inUseImm=1 inImm=32'd31 rs2=6 op=SRL -> inputB=31, ALUSelect=8; later wb x6 in stall
//      leaves inputB=31.
//   6. Load x5, issue, assert reset mid-transfer -> immediately outValid=0, inputA=0; after
//      release issue rs1=5 -> inputA=0.

Source files
------------

// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage feeding the ALU: register file with x0 tied to zero,
// write-back bypass into reads, and a one-entry valid/ready output register
// whose held operands are refreshed by write-back while stalled.
module alu_operand_fetch #(
  parameter int unsigned dataWidth   = 32,
  parameter int unsigned selectWidth = 4,
  parameter int unsigned regCount    = 32,
  parameter int unsigned addrWidth   = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [addrWidth-1:0]   inRs1,
  input  logic [addrWidth-1:0]   inRs2,
  input  logic [addrWidth-1:0]   inRd,
  input  logic [selectWidth-1:0] inALUSelect,
  input  logic                   inUseImm,
  input  logic [dataWidth-1:0]   inImm,
  input  logic                   wbEnable,
  input  logic [addrWidth-1:0]   wbAddr,
  input  logic [dataWidth-1:0]   wbData,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [dataWidth-1:0]   inputA,
  output logic [dataWidth-1:0]   inputB,
  output logic [selectWidth-1:0] ALUSelect,
  output logic [addrWidth-1:0]   outRd
);

  logic [dataWidth-1:0]   regs_q [regCount];

  logic                   out_valid_q, out_valid_d;
  logic [dataWidth-1:0]   input_a_q, input_a_d;
  logic [dataWidth-1:0]   input_b_q, input_b_d;
  logic [selectWidth-1:0] alu_sel_q, alu_sel_d;
  logic [addrWidth-1:0]   out_rd_q, out_rd_d;
  logic [addrWidth-1:0]   held_rs1_q, held_rs1_d;
  logic [addrWidth-1:0]   held_rs2_q, held_rs2_d;
  logic                   held_use_imm_q, held_use_imm_d;

  logic                   accept;
  logic                   wb_write;
  logic [dataWidth-1:0]   rs1_val;
  logic [dataWidth-1:0]   rs2_val;

  assign inReady  = !out_valid_q || outReady;
  assign accept   = inValid && inReady;
  assign wb_write = wbEnable && (wbAddr != '0);

  // Source A read: x0 is zero, same-cycle write-back wins over the array
  always_comb begin
    rs1_val = '0;
    if (inRs1 != '0) begin
      if (wbEnable && (wbAddr == inRs1)) rs1_val = wbData;
      else                               rs1_val = regs_q[inRs1];
    end
  end

  // Source B read: same rules as source A
  always_comb begin
    rs2_val = '0;
    if (inRs2 != '0) begin
      if (wbEnable && (wbAddr == inRs2)) rs2_val = wbData;
      else                               rs2_val = regs_q[inRs2];
    end
  end

  // Output register next state: capture on accept, drain, or refresh while stalled
  always_comb begin
    out_valid_d    = out_valid_q;
    input_a_d      = input_a_q;
    input_b_d      = input_b_q;
    alu_sel_d      = alu_sel_q;
    out_rd_d       = out_rd_q;
    held_rs1_d     = held_rs1_q;
    held_rs2_d     = held_rs2_q;
    held_use_imm_d = held_use_imm_q;

    if (accept) begin
      out_valid_d    = 1'b1;
      input_a_d      = rs1_val;
      input_b_d      = inUseImm ? inImm : rs2_val;
      alu_sel_d      = inALUSelect;
      out_rd_d       = inRd;
      held_rs1_d     = inRs1;
      held_rs2_d     = inRs2;
      held_use_imm_d = inUseImm;
    end else if (out_valid_q && outReady) begin
      out_valid_d = 1'b0;
    end else if (out_valid_q && wb_write) begin
      // Stalled operands track younger write-backs to their source registers
      if (wbAddr == held_rs1_q) input_a_d = wbData;
      if (!held_use_imm_q && (wbAddr == held_rs2_q)) input_b_d = wbData;
    end
  end

  // Output/held-source state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q    <= 1'b0;
      input_a_q      <= '0;
      input_b_q      <= '0;
      alu_sel_q      <= '0;
      out_rd_q       <= '0;
      held_rs1_q     <= '0;
      held_rs2_q     <= '0;
      held_use_imm_q <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_d;
      input_a_q      <= input_a_d;
      input_b_q      <= input_b_d;
      alu_sel_q      <= alu_sel_d;
      out_rd_q       <= out_rd_d;
      held_rs1_q     <= held_rs1_d;
      held_rs2_q     <= held_rs2_d;
      held_use_imm_q <= held_use_imm_d;
    end
  end

  // Register file write port; x0 is never written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < regCount; i++) regs_q[i] <= '0;
    end else if (wb_write) begin
      regs_q[wbAddr] <= wbData;
    end
  end

  assign outValid  = out_valid_q;
  assign inputA    = input_a_q;
  assign inputB    = input_b_q;
  assign ALUSelect = alu_sel_q;
  assign outRd     = out_rd_q;

endmodule
